mram_burst_reader: RTL

Parametrised successor to the single-byte MRAM output capture. On a read trigger it sequences a burst of MRAM reads: it drives the address, EN and R_CLK with programmable pre-charge and read timing. It captures NUM_CH parallel MRAM data lanes per address into per-channel FIFOs. It drains them as one valid/ready stream tagged with the channel number, and stalls the MRAM sequencer on back-pressure instead of dropping data.

---
 rtl/mram_rd_pkg.sv | 28 ++
 rtl/mram_cap_fifo.sv | 56 +++++
 rtl/mram_burst_reader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mram_rd_pkg.sv
// Shared types and helpers for the MRAM burst reader.
// Sequencer states, lane-index width and timing-counter width.
package mram_rd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHK,
      PRE,
      READ,
      CAPT
   } rd_state_t;

   localparam int CYCLE_TPRE_DEF  = 2;
   localparam int CYCLE_TREAD_DEF = 4;

   // Width of the lane index; a single lane still gets one bit.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width needed to count down the longer of the two phases.
   function automatic int tcnt_w(input int tpre, input int tread);
      return $clog2(((tpre > tread) ? tpre : tread) + 1);
   endfunction

   localparam int TCNT_W = tcnt_w(CYCLE_TPRE_DEF, CYCLE_TREAD_DEF);

endpackage

// File: rtl/mram_cap_fifo.sv
// Per-lane capture FIFO, first-word-fall-through.
// Head word is visible on rdata whenever empty is low.
module mram_cap_fifo #(
   parameter int DATA_W = 8,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rd,
   output logic [DATA_W-1:0] rdata,
   output logic [AW:0]       count,
   output logic              empty,
   output logic              full
);

   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] FULL_C = {1'b1, {AW{1'b0}}};

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wp;
   logic [AW-1:0]     rp;
   logic              do_rd;

   assign do_rd = rd && !empty;
   assign empty = (count == '0);
   assign full  = (count == FULL_C);
   assign rdata = mem[rp];

   // Storage array; contents need no reset.
   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= wdata;
   end

   // Pointers and occupancy; read+write together keeps count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (wr)    wp <= wp + 1'b1;
         if (do_rd) rp <= rp + 1'b1;
         unique case ({wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   a_no_ovf: assert property (
      @(posedge clk) disable iff (rst) !(wr && full));

endmodule

// File: rtl/mram_burst_reader.sv
// Burst MRAM reader: sequences EN/A/R_CLK per word and
// streams captured lanes out address-major with back-pressure.
module mram_burst_reader
   import mram_rd_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int NUM_CH      = 2,
   parameter int ADDR_W      = 14,
   parameter int FIFO_AW     = 4,
   parameter int CYCLE_TPRE  = CYCLE_TPRE_DEF,
   parameter int CYCLE_TREAD = CYCLE_TREAD_DEF,
   localparam int CH_W       = ch_w(NUM_CH)
) (
   input  logic                     CLK,
   input  logic                     Rst,
   input  logic                     rd_trigger,
   input  logic [ADDR_W-1:0]        start_addr,
   input  logic [ADDR_W-1:0]        burst_len,
   input  logic [NUM_CH*DATA_W-1:0] out_from_mram,
   output logic [ADDR_W-1:0]        A,
   output logic                     EN,
   output logic                     R_CLK,
   output logic [DATA_W-1:0]        dout,
   output logic [CH_W-1:0]          dout_ch,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic                     busy,
   output logic                     done
);

   localparam int TW_REQ = tcnt_w(CYCLE_TPRE, CYCLE_TREAD);
   localparam int TW     = (TW_REQ > TCNT_W) ? TW_REQ : TCNT_W;

   localparam logic [TW-1:0]      PRE_LD  = TW'(CYCLE_TPRE - 1);
   localparam logic [TW-1:0]      RD_LD   = TW'(CYCLE_TREAD - 1);
   localparam logic [CH_W-1:0]    LAST_CH = CH_W'(NUM_CH - 1);
   localparam logic [FIFO_AW:0]   DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

   rd_state_t         state;
   logic              trig_q;
   logic              trig_edge;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] len;
   logic [ADDR_W-1:0] wc;
   logic [TW-1:0]     tcnt;
   logic [CH_W-1:0]   ptr;
   logic              room;
   logic              xfer;
   logic              capt;
   logic [NUM_CH-1:0] emp;
   logic [NUM_CH-1:0] ful;
   logic [NUM_CH-1:0] rd_en;
   logic [FIFO_AW:0]  cnt  [NUM_CH];
   logic [DATA_W-1:0] head [NUM_CH];

   assign trig_edge  = rd_trigger && !trig_q;
   assign capt       = (state == CAPT);
   assign dout_valid = !emp[ptr];
   assign xfer       = dout_valid && dout_ready;
   assign dout       = dout_valid ? head[ptr] : '0;
   assign dout_ch    = ptr;

   // A new word is fetched only when every lane has a free slot.
   always_comb begin
      room = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
         if (cnt[k] >= DEPTH_C) room = 1'b0;
      end
   end

   // Pop only the lane under the drain pointer.
   always_comb begin
      rd_en = '0;
      if (xfer) rd_en[ptr] = 1'b1;
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      mram_cap_fifo #(
         .DATA_W (DATA_W),
         .AW     (FIFO_AW)
      ) u_fifo (
         .clk   (CLK),
         .rst   (Rst),
         .wr    (capt),
         .wdata (out_from_mram[k*DATA_W +: DATA_W]),
         .rd    (rd_en[k]),
         .rdata (head[k]),
         .count (cnt[k]),
         .empty (emp[k]),
         .full  (ful[k])
      );
   end

   // Round-robin drain pointer gives address-major order.
   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst) begin
         ptr <= '0;
      end else if (xfer) begin
         ptr <= (ptr == LAST_CH) ? '0 : ptr + 1'b1;
      end
   end

   // Read sequencer with registered MRAM controls.
   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst) begin
         state  <= IDLE;
         trig_q <= 1'b0;
         base   <= '0;
         len    <= '0;
         wc     <= '0;
         tcnt   <= '0;
         A      <= '0;
         EN     <= 1'b0;
         R_CLK  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         trig_q <= rd_trigger;
         done   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (trig_edge) begin
                  base  <= start_addr;
                  len   <= burst_len;
                  wc    <= '0;
                  busy  <= 1'b1;
                  state <= CHK;
               end
            end
            CHK: begin
               if (room) begin
                  A     <= base + wc;
                  EN    <= 1'b1;
                  tcnt  <= PRE_LD;
                  state <= PRE;
               end
            end
            PRE: begin
               if (tcnt == '0) begin
                  R_CLK <= 1'b1;
                  tcnt  <= RD_LD;
                  state <= READ;
               end else begin
                  tcnt <= tcnt - 1'b1;
               end
            end
            READ: begin
               if (tcnt == '0) begin
                  R_CLK <= 1'b0;
                  state <= CAPT;
               end else begin
                  tcnt <= tcnt - 1'b1;
               end
            end
            CAPT: begin
               EN <= 1'b0;
               if (wc == len) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  wc    <= wc + 1'b1;
                  state <= CHK;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_capt_room: assert property (
      @(posedge CLK) disable iff (Rst) !(capt && |ful));

endmodule
